// File: rtl/detector_sentido_pkg.sv
// Shared definitions for the presence-sensor blocks: state encodings, event codes
// and default sizing, so display/control logic decodes them the same way.
package detector_sentido_pkg;

    localparam int CAPACIDAD_DEF = 15;
    localparam int ANCHO_DEF     = 4;
    localparam int TIMEOUT_DEF   = 5000;

    typedef enum logic [2:0] {
        REPOSO       = 3'd0,
        ENT_A        = 3'd1,
        ENT_AB       = 3'd2,
        ENT_B        = 3'd3,
        SAL_B        = 3'd4,
        SAL_BA       = 3'd5,
        SAL_A        = 3'd6,
        ESPERA_LIBRE = 3'd7
    } estado_t;

    typedef logic [2:0] evento_t;

    localparam evento_t EV_NINGUNO = 3'd0;
    localparam evento_t EV_ENTRADA = 3'd1;
    localparam evento_t EV_SALIDA  = 3'd2;
    localparam evento_t EV_ERROR   = 3'd3;

    // The sequence timer only runs while a passage is in progress.
    function automatic logic es_reposo(input estado_t e);
        return (e == REPOSO) || (e == ESPERA_LIBRE);
    endfunction

endpackage

// File: rtl/detector_sentido_temporizador_secuencia.sv
// Sequence timer: counts cycles while a passage is in progress and flags when the
// sequence has reached its time limit. Saturates at the terminal value.
module temporizador_secuencia
    import detector_sentido_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic vencido
);

    localparam int            TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] FIN = TW'(TIMEOUT - 1);

    logic [TW-1:0] cuenta_q;
    logic [TW-1:0] cuenta_d;

    // Next count: clear while idle, otherwise count up and hold at the terminal value.
    always_comb begin
        cuenta_d = cuenta_q;
        if (clear) begin
            cuenta_d = '0;
        end else if (cuenta_q != FIN) begin
            cuenta_d = cuenta_q + TW'(1);
        end else begin
            cuenta_d = cuenta_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign vencido = (cuenta_q == FIN);

endmodule

// File: rtl/detector_sentido.sv
// Direction decoder for a two-sensor doorway (A outer, B inner): turns complete
// sensor sequences into entry/exit events and keeps a saturating occupancy count.
module detector_sentido
    import detector_sentido_pkg::*;
#(
    parameter int CAPACIDAD = CAPACIDAD_DEF,
    parameter int ANCHO     = ANCHO_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_estable,
    input  logic             b_estable,
    output logic             entrada,
    output logic             salida,
    output logic             rechazo,
    output logic             error,
    output logic [ANCHO-1:0] contador,
    output logic             lleno,
    output logic             vacio
);

    localparam logic [ANCHO-1:0] CAP = ANCHO'(CAPACIDAD);

    estado_t          estado_q, estado_d;
    evento_t          evento_s;
    logic [1:0]       ab_s;
    logic             clear_s, vencido_s;
    logic [ANCHO-1:0] contador_q, contador_d;
    logic             entrada_q, entrada_d, salida_q, salida_d;
    logic             rechazo_q, rechazo_d, error_q, error_d;
    logic             lleno_q, lleno_d, vacio_q, vacio_d;

    assign ab_s    = {a_estable, b_estable};
    assign clear_s = es_reposo(estado_q);

    temporizador_secuencia #(.TIMEOUT(TIMEOUT)) u_temporizador (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .vencido (vencido_s)
    );

    // Next state and passage event; a timeout overrides any sensor transition.
    always_comb begin
        estado_d = estado_q;
        evento_s = EV_NINGUNO;
        if (vencido_s && !clear_s) begin
            estado_d = ESPERA_LIBRE;
            evento_s = EV_ERROR;
        end else begin
            case (estado_q)
                REPOSO: case (ab_s)
                    2'b10:   estado_d = ENT_A;
                    2'b01:   estado_d = SAL_B;
                    2'b11:   begin estado_d = ESPERA_LIBRE; evento_s = EV_ERROR; end
                    default: estado_d = REPOSO;
                endcase
                ENT_A: case (ab_s)
                    2'b11:   estado_d = ENT_AB;
                    2'b00:   estado_d = REPOSO;
                    2'b01:   begin estado_d = ESPERA_LIBRE; evento_s = EV_ERROR; end
                    default: estado_d = ENT_A;
                endcase
                ENT_AB: case (ab_s)
                    2'b01:   estado_d = ENT_B;
                    2'b10:   estado_d = ENT_A;
                    2'b00:   begin estado_d = ESPERA_LIBRE; evento_s = EV_ERROR; end
                    default: estado_d = ENT_AB;
                endcase
                ENT_B: case (ab_s)
                    2'b00:   begin estado_d = REPOSO; evento_s = EV_ENTRADA; end
                    2'b11:   estado_d = ENT_AB;
                    2'b10:   begin estado_d = ESPERA_LIBRE; evento_s = EV_ERROR; end
                    default: estado_d = ENT_B;
                endcase
                SAL_B: case (ab_s)
                    2'b11:   estado_d = SAL_BA;
                    2'b00:   estado_d = REPOSO;
                    2'b10:   begin estado_d = ESPERA_LIBRE; evento_s = EV_ERROR; end
                    default: estado_d = SAL_B;
                endcase
                SAL_BA: case (ab_s)
                    2'b10:   estado_d = SAL_A;
                    2'b01:   estado_d = SAL_B;
                    2'b00:   begin estado_d = ESPERA_LIBRE; evento_s = EV_ERROR; end
                    default: estado_d = SAL_BA;
                endcase
                SAL_A: case (ab_s)
                    2'b00:   begin estado_d = REPOSO; evento_s = EV_SALIDA; end
                    2'b11:   estado_d = SAL_BA;
                    2'b01:   begin estado_d = ESPERA_LIBRE; evento_s = EV_ERROR; end
                    default: estado_d = SAL_A;
                endcase
                ESPERA_LIBRE: begin
                    if (ab_s == 2'b00) begin
                        estado_d = REPOSO;
                    end else begin
                        estado_d = ESPERA_LIBRE;
                    end
                end
                default: estado_d = REPOSO;
            endcase
        end
    end

    // Occupancy update and output pulses; a passage that would overflow/underflow is rejected.
    always_comb begin
        contador_d = contador_q;
        entrada_d  = 1'b0;
        salida_d   = 1'b0;
        rechazo_d  = 1'b0;
        error_d    = 1'b0;
        case (evento_s)
            EV_ENTRADA: begin
                if (!lleno_q) begin
                    contador_d = contador_q + ANCHO'(1);
                    entrada_d  = 1'b1;
                end else begin
                    rechazo_d  = 1'b1;
                end
            end
            EV_SALIDA: begin
                if (!vacio_q) begin
                    contador_d = contador_q - ANCHO'(1);
                    salida_d   = 1'b1;
                end else begin
                    rechazo_d  = 1'b1;
                end
            end
            EV_ERROR: error_d = 1'b1;
            default:  error_d = 1'b0;
        endcase
        lleno_d = (contador_d == CAP);
        vacio_d = (contador_d == '0);
    end

    // State, count and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= REPOSO;
            contador_q <= '0;
            entrada_q  <= 1'b0;
            salida_q   <= 1'b0;
            rechazo_q  <= 1'b0;
            error_q    <= 1'b0;
            lleno_q    <= 1'b0;
            vacio_q    <= 1'b1;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
            entrada_q  <= entrada_d;
            salida_q   <= salida_d;
            rechazo_q  <= rechazo_d;
            error_q    <= error_d;
            lleno_q    <= lleno_d;
            vacio_q    <= vacio_d;
        end
    end

    assign entrada  = entrada_q;
    assign salida   = salida_q;
    assign rechazo  = rechazo_q;
    assign error    = error_q;
    assign contador = contador_q;
    assign lleno    = lleno_q;
    assign vacio    = vacio_q;

endmodule

// File: tb/tb_detector_sentido.sv
// Bench for detector_sentido: directed passages plus random sensor activity, checked
// against a corridor-position model through an expected-pulse scoreboard.
module tb_detector_sentido;

    localparam int CAP = 3;
    localparam int AN  = 2;
    localparam int TO  = 20;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          a_estable = 1'b0;
    logic          b_estable = 1'b0;
    logic          entrada, salida, rechazo, error, lleno, vacio;
    logic [AN-1:0] contador;

    int checks = 0;
    int errors = 0;

    detector_sentido #(.CAPACIDAD(CAP), .ANCHO(AN), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_estable (a_estable),
        .b_estable (b_estable),
        .entrada   (entrada),
        .salida    (salida),
        .rechazo   (rechazo),
        .error     (error),
        .contador  (contador),
        .lleno     (lleno),
        .vacio     (vacio)
    );

    always #5 clk = ~clk;

    // Pulse codes: 0 none, 1 entrada, 2 salida, 3 rechazo, 4 error, 7 several at once.
    typedef struct {
        int kind;
        int ciclo;
    } esp_t;
    esp_t sb_q[$];

    // Model: position along the doorway (0 outside, 1..3 moving through) in a chosen direction.
    int         m_count = 0, m_dir = 0, m_pos = 0, m_t = 0, m_edge = 0, m_k, m_p;
    bit         m_wait = 1'b0;
    logic [1:0] m_ab;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pos_of(input int dir, input logic [1:0] ab);
        if (ab == 2'b00) return 0;
        if (ab == 2'b11) return 2;
        if (dir == 1) return (ab == 2'b10) ? 1 : 3;
        return (ab == 2'b01) ? 1 : 3;
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_count = 0; m_dir = 0; m_pos = 0; m_t = 0; m_wait = 1'b0;
            sb_q.delete();
        end else begin
            m_edge++;
            m_k  = 0;
            m_ab = {a_estable, b_estable};
            if (m_wait) begin
                if (m_ab == 2'b00) m_wait = 1'b0;
            end else if (m_pos == 0) begin
                if (m_ab == 2'b11) begin
                    m_wait = 1'b1; m_k = 4;
                end else if (m_ab != 2'b00) begin
                    m_dir = (m_ab == 2'b10) ? 1 : 2; m_pos = 1; m_t = 0;
                end
            end else if (m_t == TO - 1) begin
                m_wait = 1'b1; m_pos = 0; m_k = 4;
            end else begin
                m_p = pos_of(m_dir, m_ab);
                m_t++;
                if (m_p == m_pos) begin
                    m_pos = m_p;
                end else if (m_pos == 3 && m_p == 0) begin
                    m_pos = 0; m_k = (m_dir == 1) ? 1 : 2;
                end else if (m_p - m_pos == 1 || m_pos - m_p == 1) begin
                    m_pos = m_p;
                end else begin
                    m_wait = 1'b1; m_pos = 0; m_k = 4;
                end
            end
            if (m_k == 1 && m_count == CAP) m_k = 3;
            if (m_k == 2 && m_count == 0)   m_k = 3;
            if (m_k == 1) m_count++;
            if (m_k == 2) m_count--;
            if (m_k != 0) sb_q.push_back('{m_k, m_edge});
        end
    end

    int   mon_act, mon_exp, mon_n;
    esp_t mon_it;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            mon_n   = int'(entrada) + int'(salida) + int'(rechazo) + int'(error);
            mon_act = (mon_n > 1) ? 7 : entrada ? 1 : salida ? 2 : rechazo ? 3 : error ? 4 : 0;
            mon_exp = 0;
            if (sb_q.size() > 0 && sb_q[0].ciclo == m_edge) begin
                mon_it  = sb_q.pop_front();
                mon_exp = mon_it.kind;
            end
            chk("pulso", mon_act, mon_exp);
            chk("contador", int'(contador), m_count);
            chk("lleno", int'(lleno), (m_count == CAP) ? 1 : 0);
            chk("vacio", int'(vacio), (m_count == 0) ? 1 : 0);
        end
    end

    task automatic hold(input logic [1:0] ab, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {a_estable, b_estable} = ab;
        end
    endtask

    task automatic paso(input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                        input logic [1:0] s3, input int n);
        hold(s0, n); hold(s1, n); hold(s2, n); hold(s3, n);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_contador"}, int'(contador), 0);
        chk({nm, "_vacio"}, int'(vacio), 1);
        chk({nm, "_lleno"}, int'(lleno), 0);
        chk({nm, "_entrada"}, int'(entrada), 0);
        chk({nm, "_salida"}, int'(salida), 0);
        chk({nm, "_rechazo"}, int'(rechazo), 0);
        chk({nm, "_error"}, int'(error), 0);
    endtask

    logic [1:0] r_ab;
    int         r_sel;

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_inicial");
        reset = 1'b0;

        paso(2'b10, 2'b11, 2'b01, 2'b00, 3);             // entry
        paso(2'b01, 2'b11, 2'b10, 2'b00, 3);             // exit
        repeat (4) paso(2'b10, 2'b11, 2'b01, 2'b00, 3);  // fill, then one rejected
        chk("lleno_tras_llenar", int'(lleno), 1);
        paso(2'b10, 2'b11, 2'b10, 2'b00, 3);             // backs out
        hold(2'b10, 3); hold(2'b00, 3);                  // abort
        hold(2'b10, 25); hold(2'b00, 3);                 // timeout
        hold(2'b11, 3); hold(2'b00, 3);                  // ambiguous start
        paso(2'b01, 2'b11, 2'b10, 2'b00, 3);             // count 3 -> 2

        hold(2'b10, 3); hold(2'b11, 3);
        @(posedge clk);
        #2;
        chk("contador_antes_reset", int'(contador), 2);
        reset = 1'b1;
        #1;
        chk_reset_vals("reset_en_ent_ab");
        @(negedge clk);
        {a_estable, b_estable} = 2'b00;
        @(negedge clk);
        reset = 1'b0;

        repeat (250) begin
            r_sel = int'($urandom_range(0, 3));
            if (r_sel == 0) begin
                paso(2'b10, 2'b11, 2'b01, 2'b00, int'($urandom_range(1, 3)));
            end else if (r_sel == 1) begin
                paso(2'b01, 2'b11, 2'b10, 2'b00, int'($urandom_range(1, 3)));
            end else begin
                r_ab = 2'($urandom_range(0, 3));
                hold(r_ab, int'($urandom_range(1, 8)));
            end
        end
        hold(2'b00, 30);
        @(negedge clk);
        chk("cola_vacia", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
